rle_src_arb: RTL and testbench
==============================

Name: rle_src_arb

Overview:
- Sequences and shares one rle_enc instance between two byte-stream sources (ch0, ch1).
- Grants the encoder to one source for a whole stream, then drives end_of_stream and waits for the final run word.
- After the final word it pulses an encoder-local reset so every stream starts clean, then re-arbitrates round-robin.
- Tags each 24-bit encoder output word with its channel id toward a single sink FIFO.

Parameters:
FLUSH_TIMEOUT, 16, max cycles in FLUSH waiting for the final enc_wr_req before forced release
CNT_W, 16, width of the per-stream output word counter

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
src_empty  in  2  per-channel source FIFO empty
src_eos  in  2  per-channel level: no further data after FIFO drains
src_data0  in  8  ch0 FIFO head byte
src_data1  in  8  ch1 FIFO head byte
src_rd  out  2  per-channel FIFO pop strobe
enc_rst  out  1  encoder reset, ORed externally with rst
enc_recv_ready  out  1  to rle_enc recv_ready
enc_send_ready  out  1  to rle_enc send_ready
enc_in_data  out  8  to rle_enc in_data
enc_end_of_stream  out  1  to rle_enc end_of_stream
enc_rd_req  in  1  from rle_enc rd_req
enc_wr_req  in  1  from rle_enc wr_req
enc_out_data  in  24  from rle_enc out_data
sink_full  in  1  output FIFO full
sink_wr  out  1  output FIFO push
sink_data  out  25  {channel id, enc_out_data}
stat_words  out  CNT_W  words emitted by last completed stream
stat_valid  out  1  1-cycle pulse when stat_words updates
stat_timeout  out  1  sticky: a flush timed out; cleared by rst

Behaviour:
- Reset is asynchronous, active-high. On rst: state=IDLE, rr_ptr=0, enc_rst=1; stat_words=0; all other outputs 0.
- States: IDLE, STREAM, FLUSH, CLEAR.
- IDLE: a channel requests when !src_empty | src_eos.
  - Grant rr_ptr if it requests, else the other channel; none requesting -> stay.
  - Grant is registered; STREAM is entered the next cycle; word counter cleared.
- STREAM, granted channel g:
  - enc_in_data = src_data[g]; enc_recv_ready = !src_empty[g].
  - src_rd[g] = enc_rd_req & !src_empty[g]. The non-granted src_rd is always 0.
  - When src_empty[g] & src_eos[g] -> FLUSH.
- FLUSH:
  - enc_end_of_stream=1, enc_recv_ready=0, src_rd=0.
  - Timeout counter counts cycles in FLUSH.
  - Exit to CLEAR on the first enc_wr_req accepted with sink_full=0 (the final word), or when the counter reaches FLUSH_TIMEOUT; on timeout set stat_timeout.
- CLEAR (1 cycle):
  - enc_rst=1.
  - stat_words = word count including the final word; stat_valid=1.
  - rr_ptr = ~g; -> IDLE.
  - enc_rst is 0 in every state except CLEAR and reset.
- In all states enc_send_ready = !sink_full & (state is STREAM or FLUSH).
- sink_wr = enc_wr_req & enc_send_ready. sink_data = {g, enc_out_data}, combinational pass-through.
- Word counter increments on each sink_wr and saturates at all-ones.
- Boundaries:
  - Both channels requesting in IDLE -> rr_ptr wins.
  - src_eos with non-empty FIFO -> keep streaming until empty.
  - sink_full in FLUSH -> final word is held by the encoder and the timeout keeps counting.
  - Source going empty mid-stream without eos -> remain in STREAM, recv_ready=0.
  - rst mid-stream -> immediate return to IDLE; partial stream is discarded and produces no stat_valid.
- Latency: IDLE->STREAM 1 cycle; FLUSH->IDLE 2 cycles (CLEAR + IDLE entry).

Decomposition:
- Shared package rle_pkg:
  - state encoding constants (IDLE=2'd0, STREAM=2'd1, FLUSH=2'd2, CLEAR=2'd3)
  - RLE_DATA_W=8 and RLE_WORD_W=24, used by rle_enc and this block
  - CHAN_W=1
- One natural sub-module: rle_rr_pick, a 2-way round-robin selector (req[1:0], ptr -> grant, valid).
- Counters and FSM stay in the top module.

Test Plan:
1. Reset: hold rst 4 cycles mid-run -> enc_rst=1, src_rd=0, sink_wr=0, state IDLE, stat_words=0, stat_timeout=0.
2. Single stream: ch0 bytes 0xCC,0xE0,0x0F then src_eos0=1 -> only src_rd[0] toggles; end_of_stream rises after the FIFO is empty; sink_data[24]=0 on every word; stat_words equals the number of sink_wr pulses; one-cycle enc_rst.
3. Contention: both channels non-empty at reset exit -> ch0 served completely first; ch1 granted within 2 cycles after CLEAR; ch1 words carry sink_data[24]=1; no interleaving.
4. Backpressure: sink_full=1 for 10 cycles during STREAM -> enc_send_ready=0, sink_wr=0, no lost words; counts match the unstalled run.
5. Flush timeout: encoder model never asserts wr_req after eos -> exactly 16 FLUSH cycles, then CLEAR; stat_timeout=1 and stays 1.
6. Starvation: ch0 idle with src_eos0=0, ch1 streams repeatedly -> ch1 granted each time; when ch0 gets data it wins the next arbitration (rr_ptr=0).

Source files
------------

// File: rtl/rle_pkg.sv
// rtl/rle_pkg.sv - shared RLE widths, channel width and arbiter state encoding
package rle_pkg;

   localparam int RLE_DATA_W = 8;
   localparam int RLE_WORD_W = 24;
   localparam int CHAN_W     = 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_STREAM = 2'd1;
   localparam logic [1:0] ST_FLUSH  = 2'd2;
   localparam logic [1:0] ST_CLEAR  = 2'd3;

   // A channel wants the encoder if it has data or must still close its stream.
   function automatic logic chan_req(input logic empty, input logic eos);
      return !empty | eos;
   endfunction

endpackage

// File: rtl/rle_src_arb_if.sv
// rtl/rle_src_arb_if.sv - source, encoder, sink and status signals of the shared-encoder arbiter
interface rle_src_arb_if #(parameter int CNT_W = 16);
   import rle_pkg::*;

   logic [1:0]                 src_empty;
   logic [1:0]                 src_eos;
   logic [RLE_DATA_W-1:0]      src_data0;
   logic [RLE_DATA_W-1:0]      src_data1;
   logic [1:0]                 src_rd;
   logic                       enc_rst;
   logic                       enc_recv_ready;
   logic                       enc_send_ready;
   logic [RLE_DATA_W-1:0]      enc_in_data;
   logic                       enc_end_of_stream;
   logic                       enc_rd_req;
   logic                       enc_wr_req;
   logic [RLE_WORD_W-1:0]      enc_out_data;
   logic                       sink_full;
   logic                       sink_wr;
   logic [CHAN_W+RLE_WORD_W-1:0] sink_data;
   logic [CNT_W-1:0]           stat_words;
   logic                       stat_valid;
   logic                       stat_timeout;

   modport master (
      input  src_empty, src_eos, src_data0, src_data1,
      input  enc_rd_req, enc_wr_req, enc_out_data, sink_full,
      output src_rd, enc_rst, enc_recv_ready, enc_send_ready, enc_in_data, enc_end_of_stream,
      output sink_wr, sink_data, stat_words, stat_valid, stat_timeout
   );

   modport slave (
      output src_empty, src_eos, src_data0, src_data1,
      output enc_rd_req, enc_wr_req, enc_out_data, sink_full,
      input  src_rd, enc_rst, enc_recv_ready, enc_send_ready, enc_in_data, enc_end_of_stream,
      input  sink_wr, sink_data, stat_words, stat_valid, stat_timeout
   );

endinterface

// File: rtl/rle_rr_pick.sv
// rtl/rle_rr_pick.sv - 2-way round-robin selector: pointer channel wins if it requests
module rle_rr_pick (
   input  logic [1:0] req,
   input  logic       ptr,
   output logic       grant,
   output logic       valid
);

   assign valid = |req;
   assign grant = req[ptr] ? ptr : ~ptr;

endmodule

// File: rtl/rle_src_arb.sv
// rtl/rle_src_arb.sv - shares one rle_enc between two byte sources, one whole stream at a time
module rle_src_arb
   import rle_pkg::*;
#(
   parameter int FLUSH_TIMEOUT = 16,
   parameter int CNT_W         = 16
) (
   input  logic          clk,
   input  logic          rst,
   rle_src_arb_if.master bus
);

   localparam int TO_W = $clog2(FLUSH_TIMEOUT + 1);

   logic [1:0]       state;
   logic             gnt;
   logic             rr_ptr;
   logic [CNT_W-1:0] word_cnt;
   logic [CNT_W-1:0] word_cnt_nxt;
   logic [TO_W-1:0]  to_cnt;
   logic [CNT_W-1:0] stat_words_q;
   logic             stat_timeout_q;

   logic [1:0] req;
   logic       pick_gnt;
   logic       pick_valid;
   logic       in_stream;
   logic       in_flush;
   logic       src_empty_g;
   logic       src_eos_g;
   logic       send_ready;
   logic       sink_wr_i;
   logic       flush_done;
   logic       flush_to;

   assign req = {chan_req(bus.src_empty[1], bus.src_eos[1]),
                 chan_req(bus.src_empty[0], bus.src_eos[0])};

   rle_rr_pick u_pick (
      .req   (req),
      .ptr   (rr_ptr),
      .grant (pick_gnt),
      .valid (pick_valid)
   );

   assign in_stream   = (state == ST_STREAM);
   assign in_flush    = (state == ST_FLUSH);
   assign src_empty_g = bus.src_empty[gnt];
   assign src_eos_g   = bus.src_eos[gnt];
   assign send_ready  = !bus.sink_full & (in_stream | in_flush);
   assign sink_wr_i   = bus.enc_wr_req & send_ready;

   // The first word accepted in FLUSH is the encoder's final run; a timeout wins only without it.
   assign flush_done = in_flush & sink_wr_i;
   assign flush_to   = in_flush & !sink_wr_i & (to_cnt == TO_W'(FLUSH_TIMEOUT - 1));

   assign word_cnt_nxt = (sink_wr_i && word_cnt != '1) ? word_cnt + 1'b1 : word_cnt;

   assign bus.enc_recv_ready    = in_stream & !src_empty_g;
   assign bus.enc_in_data       = in_stream ? (gnt ? bus.src_data1 : bus.src_data0) : '0;
   assign bus.src_rd            = (in_stream & bus.enc_rd_req & !src_empty_g) ?
                                  (gnt ? 2'b10 : 2'b01) : 2'b00;
   assign bus.enc_end_of_stream = in_flush;
   assign bus.enc_send_ready    = send_ready;
   assign bus.sink_wr           = sink_wr_i;
   assign bus.sink_data         = {gnt, bus.enc_out_data};
   assign bus.enc_rst           = rst | (state == ST_CLEAR);
   assign bus.stat_valid        = (state == ST_CLEAR);
   assign bus.stat_words        = stat_words_q;
   assign bus.stat_timeout      = stat_timeout_q;

   // Stream sequencing: arbitrate, stream, flush, clear the encoder, hand over round-robin.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         gnt    <= 1'b0;
         rr_ptr <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_valid) begin
                  gnt   <= pick_gnt;
                  state <= ST_STREAM;
               end
            end
            ST_STREAM: begin
               if (src_empty_g & src_eos_g) state <= ST_FLUSH;
            end
            ST_FLUSH: begin
               if (flush_done | flush_to) state <= ST_CLEAR;
            end
            default: begin
               rr_ptr <= ~gnt;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

   // Per-stream output word count, restarted on every grant and saturating.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                  word_cnt <= '0;
      else if (state == ST_IDLE && pick_valid)  word_cnt <= '0;
      else                                      word_cnt <= word_cnt_nxt;
   end

   // Cycles spent in FLUSH, zero everywhere else.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           to_cnt <= '0;
      else if (in_flush) to_cnt <= to_cnt + 1'b1;
      else               to_cnt <= '0;
   end

   // Status captured on FLUSH exit so it is valid during the CLEAR pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_words_q   <= '0;
         stat_timeout_q <= 1'b0;
      end else begin
         if (flush_done | flush_to) stat_words_q <= word_cnt_nxt;
         if (flush_to)              stat_timeout_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rle_src_arb.sv
// tb/tb_rle_src_arb.sv - randomized bench for rle_src_arb with encoder model and stream scoreboard
module tb_rle_src_arb;
   import rle_pkg::*;

   localparam int FLUSH_TIMEOUT = 16;
   localparam int CNT_W         = 16;

   typedef logic [23:0] wq_t[$];
   typedef logic [7:0]  bq_t[$];

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rle_src_arb_if #(.CNT_W(CNT_W)) bus();

   rle_src_arb #(.FLUSH_TIMEOUT(FLUSH_TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Behavioural encoder: one run in progress, one output word buffer.
   logic        pend_v;
   logic [23:0] pend_d;
   logic        have_run;
   logic [7:0]  run_b;
   logic [15:0] run_n;
   logic        fin_done;
   bit          no_final = 1'b0;

   assign bus.enc_rd_req   = !pend_v;
   assign bus.enc_wr_req   = pend_v;
   assign bus.enc_out_data = pend_d;

   always @(posedge clk) begin
      if (bus.enc_rst) begin
         pend_v <= 1'b0; pend_d <= '0; have_run <= 1'b0;
         run_b <= '0; run_n <= '0; fin_done <= 1'b0;
      end else begin
         if (pend_v && bus.enc_send_ready) pend_v <= 1'b0;
         if (bus.enc_recv_ready && !pend_v) begin
            if (have_run && bus.enc_in_data == run_b && run_n != 16'hFFFF) begin
               run_n <= run_n + 16'd1;
            end else begin
               if (have_run) begin
                  pend_d <= {run_n, run_b};
                  pend_v <= 1'b1;
               end
               have_run <= 1'b1;
               run_b    <= bus.enc_in_data;
               run_n    <= 16'd1;
            end
         end else if (bus.enc_end_of_stream && !pend_v && !fin_done && !no_final) begin
            pend_d   <= have_run ? {run_n, run_b} : 24'd0;
            pend_v   <= 1'b1;
            fin_done <= 1'b1;
            have_run <= 1'b0;
         end
      end
   end

   // Reference run-length words for a whole byte stream.
   function automatic wq_t rle_ref(input bq_t b);
      wq_t w;
      int  i = 0;
      if (b.size() == 0) begin
         w.push_back(24'd0);
         return w;
      end
      while (i < b.size()) begin
         int n = 1;
         while (i + n < b.size() && b[i+n] == b[i] && n < 65535) n++;
         w.push_back({16'(n), b[i]});
         i += n;
      end
      return w;
   endfunction

   // Source FIFOs and stream-level reference model state.
   bq_t          fq0, fq1, pb0, pb1;
   bit [1:0]     pend_has = 2'b00;
   bit           cur_valid = 1'b0;
   bit           cur_chan = 1'b0;
   bit           model_ptr = 1'b0;
   bit           exp_timeout = 1'b0;
   wq_t          exp_w;
   logic [24:0]  act_w[$];
   logic [1:0]   rd_s;
   int flush_len = 0, since_clear = 0, stall_cnt = 0;
   int viol_rd = 0, viol_bp = 0, viol_pulse = 0, rst_cnt = 0;
   int streams_done = 0, streams_loaded = 0;
   bit wait_lat = 1'b0, prev_sv = 1'b0;

   task automatic update_src();
      bus.src_empty[0] = (fq0.size() == 0);
      bus.src_empty[1] = (fq1.size() == 0);
      bus.src_data0    = (fq0.size() != 0) ? fq0[0] : 8'h00;
      bus.src_data1    = (fq1.size() != 0) ? fq1[0] : 8'h00;
   endtask

   task automatic load_bytes(input bit c, input bq_t b);
      if (c) begin fq1 = b; pb1 = b; end
      else   begin fq0 = b; pb0 = b; end
      pend_has[c]    = 1'b1;
      bus.src_eos[c] = 1'b1;
      streams_loaded++;
      update_src();
   endtask

   task automatic load(input bit c, input int n);
      bq_t b;
      for (int i = 0; i < n; i++) b.push_back(8'(8'hA0 + $urandom_range(0, 2)));
      load_bytes(c, b);
   endtask

   task automatic reset_model();
      fq0.delete(); fq1.delete(); pb0.delete(); pb1.delete(); act_w.delete();
      pend_has = 2'b00; cur_valid = 1'b0; model_ptr = 1'b0; exp_timeout = 1'b0;
      wait_lat = 1'b0; prev_sv = 1'b0; stall_cnt = 0;
      bus.src_eos = 2'b00; bus.sink_full = 1'b0;
      streams_loaded = streams_done;
      update_src();
   endtask

   task automatic monitor();
      rd_s = bus.src_rd;
      if (rst) begin
         check("rst_enc_rst", 32'(bus.enc_rst), 1);
         check("rst_src_rd", 32'(bus.src_rd), 0);
         check("rst_sink_wr", 32'(bus.sink_wr), 0);
         check("rst_stat_words", 32'(bus.stat_words), 0);
         check("rst_stat_timeout", 32'(bus.stat_timeout), 0);
         check("rst_stat_valid", 32'(bus.stat_valid), 0);
         check("rst_eos", 32'(bus.enc_end_of_stream), 0);
         check("rst_recv_ready", 32'(bus.enc_recv_ready), 0);
         prev_sv = 1'b0;
         return;
      end
      since_clear++;
      if (bus.src_rd[0] && !(cur_valid && cur_chan == 1'b0)) viol_rd++;
      if (bus.src_rd[1] && !(cur_valid && cur_chan == 1'b1)) viol_rd++;
      if (bus.sink_full && (bus.sink_wr || bus.enc_send_ready)) viol_bp++;
      if (bus.stat_valid && prev_sv) viol_pulse++;
      prev_sv = bus.stat_valid;
      if (bus.enc_rst) rst_cnt++;
      if (cur_valid && wait_lat && bus.src_rd[cur_chan]) begin
         check("grant_latency", 32'(since_clear), 2);
         wait_lat = 1'b0;
      end
      if (bus.sink_wr) act_w.push_back(bus.sink_data);
      if (bus.enc_end_of_stream) begin
         if (flush_len == 0) check("eos_after_empty", 32'(bus.src_empty[cur_chan]), 1);
         flush_len++;
      end
      if (bus.stat_valid) begin
         if (!cur_valid) begin
            check("stat_valid_unexpected", 32'(bus.stat_valid), 0);
         end else begin
            check("n_words", 32'(act_w.size()), 32'(exp_w.size()));
            check("stat_words", 32'(bus.stat_words), 32'(exp_w.size()));
            foreach (act_w[i]) begin
               check("chan_tag", 32'(act_w[i][24]), 32'(cur_chan));
               if (i < exp_w.size()) check("word", 32'(act_w[i][23:0]), 32'(exp_w[i]));
            end
            if (no_final) begin
               check("flush_cycles", 32'(flush_len), FLUSH_TIMEOUT);
               exp_timeout = 1'b1;
            end
            check("stat_timeout", 32'(bus.stat_timeout), 32'(exp_timeout));
            check("clear_enc_rst", 32'(bus.enc_rst), 1);
            streams_done++;
            model_ptr = ~cur_chan;
            bus.src_eos[cur_chan] = 1'b0;
            cur_valid = 1'b0;
            since_clear = 0;
         end
      end
      if (!cur_valid && pend_has != 2'b00) begin
         cur_chan  = pend_has[model_ptr] ? model_ptr : ~model_ptr;
         exp_w     = rle_ref(cur_chan ? pb1 : pb0);
         if (no_final && exp_w.size() > 0) exp_w.pop_back();
         pend_has[cur_chan] = 1'b0;
         cur_valid = 1'b1;
         act_w.delete();
         flush_len = 0;
         wait_lat  = bus.stat_valid;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      if (rd_s[0] && fq0.size() != 0) void'(fq0.pop_front());
      if (rd_s[1] && fq1.size() != 0) void'(fq1.pop_front());
      update_src();
      bus.sink_full = (stall_cnt > 0);
      if (stall_cnt > 0) stall_cnt--;
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while ((cur_valid || pend_has != 2'b00) && k < budget) begin
         tick();
         k++;
      end
      check("idle_within_budget", 32'(cur_valid || pend_has != 2'b00), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bq_t fixed;
      bus.src_eos = 2'b00;
      bus.sink_full = 1'b0;
      update_src();
      rst = 1'b1;
      repeat (4) tick();
      rst = 1'b0;

      // Single stream on ch0 with fixed bytes.
      fixed = '{8'hCC, 8'hE0, 8'h0F};
      load_bytes(1'b0, fixed);
      wait_idle(200);

      // Reset mid-stream, then both channels ready at reset exit.
      load(1'b1, 30);
      repeat (6) tick();
      rst = 1'b1;
      reset_model();
      repeat (4) tick();
      load(1'b0, $urandom_range(3, 10));
      load(1'b1, $urandom_range(3, 10));
      rst = 1'b0;
      wait_idle(400);

      // Sink backpressure early in a long stream.
      load(1'b0, 20);
      repeat (3) tick();
      stall_cnt = 10;
      wait_idle(400);

      // ch1 streams repeatedly while ch0 stays idle, then both contend.
      repeat (3) begin
         load(1'b1, $urandom_range(0, 12));
         wait_idle(300);
      end
      load(1'b0, $urandom_range(1, 8));
      load(1'b1, $urandom_range(1, 8));
      wait_idle(400);
      repeat (6) begin
         int m = $urandom_range(1, 3);
         if (m[0]) load(1'b0, $urandom_range(0, 12));
         if (m[1]) load(1'b1, $urandom_range(0, 12));
         wait_idle(400);
      end

      // Encoder never delivers its final word.
      no_final = 1'b1;
      load(1'b0, $urandom_range(2, 8));
      wait_idle(300);
      no_final = 1'b0;
      load(1'b1, $urandom_range(2, 8));
      wait_idle(300);

      // Reset mid-stream again: sticky timeout clears, partial stream is dropped.
      load(1'b0, 30);
      repeat (5) tick();
      rst = 1'b1;
      reset_model();
      repeat (4) tick();
      rst = 1'b0;
      load(1'b1, $urandom_range(2, 8));
      wait_idle(300);
      repeat (3) tick();

      check("foreign_src_rd", 32'(viol_rd), 0);
      check("backpressure_leak", 32'(viol_bp), 0);
      check("stat_valid_width", 32'(viol_pulse), 0);
      check("enc_rst_cycles", 32'(rst_cnt), 32'(streams_done));
      check("streams_completed", 32'(streams_done), 32'(streams_loaded));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
